belfft_seq: RTL and testbench

- Hardware sequencer that programs and launches one belfft transform per request through belfft's Avalon-MM slave (register) port.
- Per run: writes size, source, destination and factor registers, reads each factor back to verify it, writes the start+interrupt-enable control word, waits for the completion interrupt, then reads the status register.
- Sits between the visualizer's audio-buffer control logic (start/done) and belfft, replacing bench-style register poking with synthesizable logic.

---
 rtl/belfft_seq.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_belfft_seq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/belfft_seq.sv
// belfft_seq: programs, verifies and launches one belfft transform per start
// request over the belfft Avalon-MM register port, then collects the status.
module belfft_seq #(
  parameter int unsigned NUM_FACTORS    = 3,
  parameter int unsigned SIF_AWIDTH     = 4,
  parameter int unsigned SIZE_ADDR      = 2,
  parameter int unsigned SOURCE_ADDR    = 3,
  parameter int unsigned DEST_ADDR      = 4,
  parameter int unsigned FACTORS_ADDR   = 8,
  parameter int unsigned CONTROL_ADDR   = 0,
  parameter int unsigned STATUS_ADDR    = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [15:0]               fft_size,
  input  logic [31:0]               src_addr,
  input  logic [31:0]               dst_addr,
  input  logic                      inverse,
  input  logic [32*NUM_FACTORS-1:0] factors,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [31:0]               status,
  output logic [SIF_AWIDTH-1:0]     s_address,
  output logic [31:0]               s_writedata,
  output logic                      s_read,
  output logic                      s_write,
  output logic [3:0]                s_byteenable,
  input  logic [31:0]               s_readdata,
  input  logic                      s_waitrequest,
  input  logic                      s_readdatavalid,
  input  logic                      irq
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int unsigned IDX_W = (NUM_FACTORS > 1) ? $clog2(NUM_FACTORS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_READ, S_RVALID, S_GAP, S_WAIT_IRQ, S_FIN
  } state_t;

  // Which register access the bus phases above currently belong to
  typedef enum logic [2:0] {
    ST_SIZE, ST_SRC, ST_DST, ST_FACT_W, ST_FACT_R, ST_CTRL, ST_STAT
  } step_t;

  state_t                r_state, w_nxt_state;
  step_t                 r_step, w_nxt_step, w_go_step;
  logic [IDX_W-1:0]      r_idx, w_nxt_idx, w_go_idx;
  logic [CNT_W-1:0]      r_cnt, w_nxt_cnt, w_cnt_inc;
  logic                  r_irq, r_irq_d, w_irq_rise;
  logic [15:0]           r_size;
  logic [31:0]           r_src, r_dst;
  logic                  r_inv;
  logic [31:0]           r_fact [NUM_FACTORS];
  logic                  r_busy, r_done, r_error, r_read, r_write;
  logic                  w_nxt_busy, w_nxt_done, w_nxt_error, w_nxt_read, w_nxt_write;
  logic [31:0]           r_status, r_wdata, w_nxt_status, w_nxt_wdata;
  logic [SIF_AWIDTH-1:0] r_addr, w_nxt_addr;
  logic [3:0]            r_be, w_nxt_be;
  logic                  w_go, w_fin, w_clr, w_accept;

  assign w_irq_rise = r_irq & ~r_irq_d;
  assign w_cnt_inc  = r_cnt + CNT_W'(1);
  assign w_accept   = (r_state == S_IDLE) && start;

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_step   <= ST_SIZE;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_irq    <= 1'b0;
      r_irq_d  <= 1'b0;
      r_size   <= '0;
      r_src    <= '0;
      r_dst    <= '0;
      r_inv    <= 1'b0;
      for (int i = 0; i < int'(NUM_FACTORS); i++) r_fact[i] <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      r_status <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_read   <= 1'b0;
      r_write  <= 1'b0;
      r_be     <= '0;
    end else begin
      r_state  <= w_nxt_state;
      r_step   <= w_nxt_step;
      r_idx    <= w_nxt_idx;
      r_cnt    <= w_nxt_cnt;
      r_irq    <= irq;
      r_irq_d  <= r_irq;
      if (w_accept) begin
        r_size <= fft_size;
        r_src  <= src_addr;
        r_dst  <= dst_addr;
        r_inv  <= inverse;
        for (int i = 0; i < int'(NUM_FACTORS); i++) r_fact[i] <= factors[32*i +: 32];
      end
      r_busy   <= w_nxt_busy;
      r_done   <= w_nxt_done;
      r_error  <= w_nxt_error;
      r_status <= w_nxt_status;
      r_addr   <= w_nxt_addr;
      r_wdata  <= w_nxt_wdata;
      r_read   <= w_nxt_read;
      r_write  <= w_nxt_write;
      r_be     <= w_nxt_be;
    end
  end

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_step   = r_step;
    w_nxt_idx    = r_idx;
    w_nxt_cnt    = r_cnt;
    w_nxt_busy   = r_busy;
    w_nxt_done   = 1'b0;
    w_nxt_error  = r_error;
    w_nxt_status = r_status;
    w_nxt_addr   = r_addr;
    w_nxt_wdata  = r_wdata;
    w_nxt_read   = r_read;
    w_nxt_write  = r_write;
    w_nxt_be     = r_be;
    w_go         = 1'b0;
    w_go_step    = r_step;
    w_go_idx     = r_idx;
    w_fin        = 1'b0;
    w_clr        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_go        = 1'b1;
          w_go_step   = ST_SIZE;
          w_go_idx    = '0;
          w_nxt_busy  = 1'b1;
          w_nxt_error = 1'b0;
        end
      end
      S_WRITE: begin
        if (!s_waitrequest) begin
          w_clr       = 1'b1;
          w_nxt_state = S_GAP;
        end
      end
      S_READ: begin
        if (!s_waitrequest) begin
          w_clr       = 1'b1;
          w_nxt_state = S_RVALID;
        end
      end
      S_RVALID: begin
        if (s_readdatavalid) begin
          if (r_step == ST_STAT) begin
            w_nxt_status = s_readdata;
            w_nxt_state  = S_GAP;
          end else if (s_readdata != r_fact[r_idx]) begin
            w_nxt_error = 1'b1;
            w_fin       = 1'b1;
          end else begin
            w_nxt_state = S_GAP;
          end
        end
      end
      S_GAP: begin
        case (r_step)
          ST_SIZE:   begin w_go = 1'b1; w_go_step = ST_SRC; end
          ST_SRC:    begin w_go = 1'b1; w_go_step = ST_DST; end
          ST_DST:    begin w_go = 1'b1; w_go_step = ST_FACT_W; w_go_idx = '0; end
          ST_FACT_W: begin w_go = 1'b1; w_go_step = ST_FACT_R; end
          ST_FACT_R: begin
            w_go = 1'b1;
            if (r_idx == IDX_W'(NUM_FACTORS - 1)) begin
              w_go_step = ST_CTRL;
            end else begin
              w_go_step = ST_FACT_W;
              w_go_idx  = r_idx + IDX_W'(1);
            end
          end
          ST_CTRL: begin
            w_nxt_state = S_WAIT_IRQ;
            w_nxt_cnt   = '0;
          end
          default: w_fin = 1'b1;
        endcase
      end
      S_WAIT_IRQ: begin
        if (w_irq_rise) begin
          w_go      = 1'b1;
          w_go_step = ST_STAT;
          w_nxt_cnt = '0;
        end else if (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
          w_nxt_error = 1'b1;
          w_fin       = 1'b1;
        end else begin
          w_nxt_cnt = w_cnt_inc;
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase

    if (w_clr) begin
      w_nxt_read  = 1'b0;
      w_nxt_write = 1'b0;
      w_nxt_addr  = '0;
      w_nxt_wdata = '0;
      w_nxt_be    = '0;
    end

    if (w_fin) begin
      w_nxt_state = S_FIN;
      w_nxt_done  = 1'b1;
      w_nxt_busy  = 1'b0;
      w_nxt_cnt   = '0;
    end

    // Launch the next register access; size comes straight from the input on accept
    if (w_go) begin
      w_nxt_step  = w_go_step;
      w_nxt_idx   = w_go_idx;
      w_nxt_be    = 4'hF;
      w_nxt_wdata = '0;
      w_nxt_read  = 1'b0;
      w_nxt_write = 1'b1;
      w_nxt_state = S_WRITE;
      case (w_go_step)
        ST_SIZE: begin
          w_nxt_addr  = SIF_AWIDTH'(SIZE_ADDR);
          w_nxt_wdata = {16'h0, fft_size};
        end
        ST_SRC: begin
          w_nxt_addr  = SIF_AWIDTH'(SOURCE_ADDR);
          w_nxt_wdata = r_src;
        end
        ST_DST: begin
          w_nxt_addr  = SIF_AWIDTH'(DEST_ADDR);
          w_nxt_wdata = r_dst;
        end
        ST_FACT_W: begin
          w_nxt_addr  = SIF_AWIDTH'(FACTORS_ADDR + 32'(w_go_idx));
          w_nxt_wdata = r_fact[w_go_idx];
        end
        ST_FACT_R: begin
          w_nxt_addr  = SIF_AWIDTH'(FACTORS_ADDR + 32'(w_go_idx));
          w_nxt_read  = 1'b1;
          w_nxt_write = 1'b0;
          w_nxt_state = S_READ;
        end
        ST_CTRL: begin
          w_nxt_addr  = SIF_AWIDTH'(CONTROL_ADDR);
          w_nxt_wdata = {15'h0, r_inv, 16'h0101};
        end
        default: begin
          w_nxt_addr  = SIF_AWIDTH'(STATUS_ADDR);
          w_nxt_read  = 1'b1;
          w_nxt_write = 1'b0;
          w_nxt_state = S_READ;
        end
      endcase
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_error;
  assign status       = r_status;
  assign s_address    = r_addr;
  assign s_writedata  = r_wdata;
  assign s_read       = r_read;
  assign s_write      = r_write;
  assign s_byteenable = r_be;

  // r_size is held for visibility of the request only; the size write uses the live input
  logic w_unused;
  assign w_unused = ^r_size;

endmodule

// File: tb/tb_belfft_seq.sv
// Bench for belfft_seq: behavioural belfft slave plus a scoreboard of expected
// register transfers, driven from a table of runs and a mid-run reset sequence.
module tb_belfft_seq;

  localparam int unsigned NF = 3;
  localparam int unsigned TO = 100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [15:0]   fft_size = '0;
  logic [31:0]   src_addr = '0, dst_addr = '0;
  logic          inverse = 1'b0;
  logic [32*NF-1:0] factors = '0;
  logic          busy, done, error;
  logic [31:0]   status;
  logic [3:0]    s_address;
  logic [31:0]   s_writedata;
  logic          s_read, s_write;
  logic [3:0]    s_byteenable;
  logic [31:0]   s_readdata = '0;
  logic          s_waitrequest = 1'b0, s_readdatavalid = 1'b0, irq = 1'b0;

  belfft_seq #(.NUM_FACTORS(NF), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .fft_size(fft_size), .src_addr(src_addr),
    .dst_addr(dst_addr), .inverse(inverse), .factors(factors), .busy(busy), .done(done),
    .error(error), .status(status), .s_address(s_address), .s_writedata(s_writedata),
    .s_read(s_read), .s_write(s_write), .s_byteenable(s_byteenable), .s_readdata(s_readdata),
    .s_waitrequest(s_waitrequest), .s_readdatavalid(s_readdatavalid), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] size;
    logic [31:0] src, dst;
    logic        inv;
    logic [31:0] f0, f1, f2;
    bit          stall;
    int          bad;
    bit          irq_en;
    logic [31:0] stat_val;
    logic        exp_err;
    logic [31:0] exp_stat;
  } vec_t;

  typedef struct packed {
    logic        rd;
    logic [3:0]  addr;
    logic [31:0] data;
  } txn_t;

  txn_t        exp_q[$];
  int          errors = 0, checks = 0, cyc = 0;
  bit          cur_stall = 0, cur_irq = 0, stall_taken = 0, ctrl_seen = 0, rd_pend = 0, hold_bad = 0;
  int          cur_bad = -1, stall_rem = 0, irq_cnt = 0, hold = 0, stat_reads = 0, wait_entry = 0;
  logic [31:0] cur_stat = '0, rd_val = '0, hold_data = '0;
  logic [3:0]  hold_addr = '0;
  logic [31:0] regs [16];
  vec_t        tbl [5];
  vec_t        post;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Slave model and transfer monitor, evaluated mid-cycle
  always @(negedge clk) begin
    txn_t got, e;
    if (rst) begin
      s_waitrequest = 1'b0; s_readdatavalid = 1'b0; s_readdata = '0; irq = 1'b0;
      rd_pend = 0; stall_rem = 0; irq_cnt = 0; hold = 0; hold_bad = 0;
    end else begin
      if (s_write && s_address == 4'd4 && cur_stall && !stall_taken) begin
        stall_rem = 3; stall_taken = 1;
      end
      if (stall_rem > 0) begin s_waitrequest = 1'b1; stall_rem--; end
      else s_waitrequest = 1'b0;
      s_readdatavalid = 1'b0;
      if (rd_pend) begin s_readdatavalid = 1'b1; s_readdata = rd_val; rd_pend = 0; end
      irq = 1'b0;
      if (irq_cnt > 0) begin irq_cnt--; if (irq_cnt == 0) irq = 1'b1; end
      if (s_write) begin
        if (hold == 0) begin hold_addr = s_address; hold_data = s_writedata; end
        else if (s_address != hold_addr || s_writedata != hold_data) hold_bad = 1;
        hold++;
      end
      if ((s_write || s_read) && !s_waitrequest) begin
        got = {s_read, s_address, s_read ? 32'h0 : s_writedata};
        chk("byteenable", 128'(s_byteenable), 128'(4'hF));
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_txn: got %0h expected none", got);
        end else begin
          e = exp_q.pop_front();
          chk("txn", 128'(got), 128'(e));
        end
        if (s_write) begin
          regs[s_address] = s_writedata;
          chk("write_stable", 128'(hold_bad), 128'(0));
          if (s_address == 4'd4 && cur_stall) chk("stall_hold_cycles", 128'(hold), 128'(4));
          if (s_address == 4'd0) begin
            ctrl_seen = 1;
            wait_entry = cyc + 2;
            if (cur_irq) irq_cnt = 50;
          end
          hold = 0; hold_bad = 0;
        end else begin
          rd_pend = 1;
          if (s_address == 4'd1) begin rd_val = cur_stat; stat_reads++; end
          else if (int'(s_address) == 8 + cur_bad) rd_val = 32'hDEADBEEF;
          else rd_val = regs[s_address];
        end
      end
    end
  end

  task automatic begin_run(input vec_t v);
    logic [31:0] f [3];
    f[0] = v.f0; f[1] = v.f1; f[2] = v.f2;
    cur_stall = v.stall; cur_bad = v.bad; cur_irq = v.irq_en; cur_stat = v.stat_val;
    stall_taken = 0; ctrl_seen = 0; stat_reads = 0;
    exp_q.delete();
    exp_q.push_back({1'b0, 4'd2, 16'h0, v.size});
    exp_q.push_back({1'b0, 4'd3, v.src});
    exp_q.push_back({1'b0, 4'd4, v.dst});
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({1'b0, 4'(8 + i), f[i]});
      exp_q.push_back({1'b1, 4'(8 + i), 32'h0});
      if (i == v.bad) break;
    end
    if (v.bad < 0) begin
      exp_q.push_back({1'b0, 4'd0, 15'h0, v.inv, 16'h0101});
      if (v.irq_en) exp_q.push_back({1'b1, 4'd1, 32'h0});
    end
    @(negedge clk);
    fft_size = v.size; src_addr = v.src; dst_addr = v.dst; inverse = v.inv;
    factors = {v.f2, v.f1, v.f0};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 128'(busy), 128'(1));
    chk("first_write", 128'({s_write, s_address, s_writedata}), 128'({1'b1, 4'd2, 16'h0, v.size}));
    fft_size = 16'($urandom()); src_addr = $urandom(); dst_addr = $urandom();
    factors = {$urandom(), $urandom(), $urandom()}; inverse = ~v.inv;
  endtask

  task automatic finish_run(input vec_t v, input bit poke_fin);
    int n = 0;
    while (!done && n < 3000) begin @(negedge clk); n++; end
    if (!done) begin
      checks++; errors++;
      $display("FAIL done_wait: got no done expected done within 3000 cycles");
      exp_q.delete();
    end else begin
      chk("busy_in_fin", 128'(busy), 128'(0));
      chk("error", 128'(error), 128'(v.exp_err));
      chk("status", 128'(status), 128'(v.exp_stat));
      chk("queue_drained", 128'(exp_q.size()), 128'(0));
      if (!v.irq_en) begin
        chk("timeout_len", 128'(cyc - wait_entry), 128'(TO));
        chk("no_status_read", 128'(stat_reads), 128'(0));
      end
      if (v.bad >= 0) chk("no_ctrl_write", 128'(ctrl_seen), 128'(0));
      if (poke_fin) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("done_one_cycle", 128'({done, busy, s_write, s_read}), 128'(0));
    end
  endtask

  initial begin
    int n;
    //       size    src           dst           inv f0            f1            f2          stall bad irq stat     err  exp_stat
    tbl[0] = '{16'd64,  32'h100,    32'h200,    1'b0, 32'h00040010, 32'h00040004, 32'h00040001, 0, -1, 1, 32'h1,  1'b0, 32'h1};
    tbl[1] = '{16'd256, 32'h1000,   32'h2000,   1'b0, 32'h00040040, 32'h00040010, 32'h00040004, 1, -1, 1, 32'h3,  1'b0, 32'h3};
    tbl[2] = '{16'd64,  32'h300,    32'h400,    1'b0, 32'h00040010, 32'h00040004, 32'h00040001, 0,  1, 1, 32'h9,  1'b1, 32'h3};
    tbl[3] = '{16'd16,  32'h500,    32'h600,    1'b1, 32'h00040004, 32'h00020002, 32'h00020001, 0, -1, 1, 32'h11, 1'b0, 32'h11};
    tbl[4] = '{16'd8,   32'h700,    32'h800,    1'b0, 32'h00020004, 32'h00020002, 32'h00020001, 0, -1, 0, 32'h5,  1'b1, 32'h11};
    post   = '{16'd32,  32'hA00,    32'hB00,    1'b0, 32'h00040008, 32'h00040002, 32'h00020001, 0, -1, 1, 32'h7,  1'b0, 32'h7};
    for (int i = 0; i < 16; i++) regs[i] = '0;

    repeat (2) @(negedge clk);
    chk("reset_outputs", 128'({busy, done, error, status, s_address, s_writedata, s_read, s_write, s_byteenable}), 128'(0));
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      begin_run(tbl[i]);
      finish_run(tbl[i], i == 0);
    end

    // Reset while the first factor read is on the bus
    begin_run(tbl[0]);
    n = 0;
    while (!(s_read && s_address == 4'd8) && n < 200) begin @(negedge clk); n++; end
    chk("reach_fact0_read", 128'({s_read, s_address}), 128'({1'b1, 4'd8}));
    #2 rst = 1'b1;
    #1 chk("rst_drops_bus", 128'({s_read, s_write, busy, done}), 128'(0));
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_done", 128'({done, busy, error}), 128'(0));
    end
    #2 rst = 1'b0;
    begin_run(post);
    finish_run(post, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
